// File: rtl/vga_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (renderer, sync pins, frame-rate game logic).
interface vga_if;
    logic       pix_en;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_tick;

    modport master (output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick);
    modport slave  (input  pix_en, hCount, vCount, hSync, vSync, bright, frame_tick);
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: clock divider to pixel rate, h/v counters, sync and
// visible-area decodes, and a registered once-per-frame tick.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VIS   = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VIS   = 480,
    parameter int V_FRONT = 10
) (
    input  logic  clk,
    input  logic  rst,
    vga_if.master vga
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VIS + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VIS + V_FRONT;

    localparam logic [3:0] DIV_MAX   = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_HI  = 10'(H_SYNC + H_BACK + H_VIS);
    localparam logic [9:0] V_VIS_LO  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_HI  = 10'(V_SYNC + V_BACK + V_VIS);

    logic [3:0] r_div_cnt;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_frame_tick;

    logic w_pix_en;
    logic w_h_last;
    logic w_v_last;

    assign w_pix_en = (r_div_cnt == DIV_MAX);
    assign w_h_last = (r_h_cnt == H_MAX);
    assign w_v_last = (r_v_cnt == V_MAX);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, matching the hardware it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt    <= '0;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            // Set only on the edge that wraps both counters back to (0,0).
            r_frame_tick <= w_pix_en && w_h_last && w_v_last;
            if (w_pix_en) begin
                r_div_cnt <= '0;
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 4'd1;
            end
        end
    end

    // Decodes are combinational so they line up with the counter values they describe.
    assign vga.pix_en     = w_pix_en;
    assign vga.hCount     = r_h_cnt;
    assign vga.vCount     = r_v_cnt;
    assign vga.hSync      = (r_h_cnt >= H_SYNC_W);
    assign vga.vSync      = (r_v_cnt >= V_SYNC_W);
    assign vga.bright     = (r_h_cnt >= H_VIS_LO) && (r_h_cnt < H_VIS_HI) &&
                            (r_v_cnt >= V_VIS_LO) && (r_v_cnt < V_VIS_HI);
    assign vga.frame_tick = r_frame_tick;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output. Divides the 100 MHz board clock into a pixel-rate enable and runs the horizontal and vertical counters. Decodes the counters into hSync, vSync and bright. Directly feeds the block/object renderer (hCount, vCount, bright) and the VGA pins (hSync, vSync), and provides a once-per-frame tick for game-state update logic.

## Interface
- CLK_DIV, 4: board clocks per pixel; 100 MHz / 4 = 25 MHz. Legal range 2..16.
- H_SYNC, 96; H_BACK, 48; H_VIS, 640; H_FRONT, 16: horizontal segment lengths in pixels. H_TOTAL = 800.
- V_SYNC, 2; V_BACK, 33; V_VIS, 480; V_FRONT, 10: vertical segment lengths in lines. V_TOTAL = 525.
- clk  in  1  board clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pix_en  out  1  one-clk-wide pulse once every CLK_DIV clocks.
- hCount  out  10  horizontal pixel counter, 0..H_TOTAL-1.
- vCount  out  10  vertical line counter, 0..V_TOTAL-1.
- hSync  out  1  active-low horizontal sync.
- vSync  out  1  active-low vertical sync.
- bright  out  1  high inside the visible area.
- frame_tick  out  1  one-clk pulse at the start of each frame.

## Operation
- Divider div_cnt, width 4, counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt == CLK_DIV-1). pix_en is decoded from the register.
- On an edge with pix_en = 1:
  - hCount increments.
  - When hCount = H_TOTAL-1, hCount goes to 0 and vCount advances.
  - vCount increments; when vCount = V_TOTAL-1 it goes to 0.
  - vCount changes only on the edge where hCount wraps.
- Segment layout, measured from count 0:
  - Horizontal: sync 0..95, back porch 96..143, visible 144..783, front porch 784..799.
  - Vertical: sync 0..1, back porch 2..34, visible 35..514, front porch 515..524.
- hSync = 0 when hCount < H_SYNC, otherwise 1.
- vSync = 0 when vCount < V_SYNC, otherwise 1.
- bright = 1 only when both hold:
  - H_SYNC+H_BACK <= hCount < H_SYNC+H_BACK+H_VIS
  - V_SYNC+V_BACK <= vCount < V_SYNC+V_BACK+V_VIS
- hSync, vSync and bright are combinational decodes of the registered counters. They are therefore valid in the same clk cycle as the hCount/vCount values they describe.
- frame_tick is a register. It is set on the edge where both counters wrap to (0,0). It clears on the next edge. Exactly one assertion per frame.
- All comparisons are unsigned, 10-bit. The counters never exceed their TOTAL-1 values.

## Timing
- Reset values (rst = 0, asynchronous): div_cnt = 0, hCount = 0, vCount = 0, frame_tick = 0.
- Decoded outputs while in reset: pix_en = 0 (when CLK_DIV > 1), hSync = 0, vSync = 0, bright = 0.
- After rst rises:
  - First pix_en occurs in clk cycle CLK_DIV-1, counting the first post-reset edge as cycle 0.
  - hCount first reads 1 after CLK_DIV edges.
- Reset release does not generate frame_tick. The first frame_tick occurs after a full frame: 800*525*CLK_DIV clocks.
- Line period is 800*CLK_DIV clocks. Frame period is 420000*CLK_DIV clocks, which is 1,680,000 at the defaults.
- hSync low width is 96*CLK_DIV clocks. vSync low width is 2 lines = 1600*CLK_DIV clocks.
- Reset asserted mid-frame: all state returns to the reset values immediately, with no wait for a clock edge. A frame_tick in progress is cleared.
- Downstream consumers sample hCount/vCount/bright on any clk edge. Values are stable for CLK_DIV clocks between pix_en edges.

## Test plan
- Reset: hold rst = 0 for 10 clocks mid-run -> hCount = 0, vCount = 0, hSync = 0, vSync = 0, bright = 0, frame_tick = 0 within the same cycle as rst falling.
- Divider: release reset, count clocks -> pix_en high in cycles 3, 7, 11, … (CLK_DIV = 4), and one cycle wide each time.
- Horizontal: run one line ->
  - hSync low for hCount 0..95 and high at 96.
  - hCount 799 -> 0 with vCount 0 -> 1 on the same edge.
  - Line length = 3200 clocks.
- Visible window:
  - bright = 0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (144,515).
  - bright is never high while hSync or vSync is low.
- Frame wrap: run 2 frames ->
  - vCount 524 -> 0 at hCount wrap.
  - frame_tick high for exactly 1 clock at each (0,0) entry.
  - The two ticks are 1,680,000 clocks apart.
  - vSync low for vCount 0..1 only.
- Parameter sweep: CLK_DIV = 2 -> line = 1600 clocks, frame = 840,000 clocks, all segment boundaries unchanged in count values.
